// File: rtl/mask_pkg.sv
// Shared definitions for the mask row streamer slice.
//   ms_state_t      : streamer FSM states
//   MASK_WORD_W     : default output word width in pixels
//   MASK_IDX_W      : word-index width for a 1920-pixel row of 32-pixel words
//   MASK_DIM_W      : width of row/width/height quantities
//   mask_word_count : words per row, ceil(width / word width), 12-bit arithmetic
package mask_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MASK,
    SEND,
    DONE
  } ms_state_t;

  localparam int MASK_WORD_W = 32;
  localparam int MASK_IDX_W  = $clog2((1920 + 32 - 1) / 32);
  localparam int MASK_DIM_W  = 11;

  function automatic logic [11:0] mask_word_count(input logic [11:0] width,
                                                  input logic [11:0] wword);
    return (width + wword - 12'd1) / wword;
  endfunction

endpackage

// File: rtl/mask_row_streamer_if.sv
// Word stream from the mask row streamer to the pixel-array mask loader.
//   out_word       : [0:word_w-1], lane k is pixel out_word_idx*word_w+k
//   out_valid      : word available
//   out_ready      : downstream accepts
//   out_row        : row index of out_word
//   out_word_idx   : word index within the row
//   out_last_word  : last word of its row
//   out_last_row   : last row of the frame
// master = streamer side, slave = loader side.
interface mask_row_streamer_if
  import mask_pkg::*;
#(
  parameter int word_w = MASK_WORD_W
);

  logic [0:word_w-1]       out_word;
  logic                    out_valid;
  logic                    out_ready;
  logic [MASK_DIM_W-1:0]   out_row;
  logic [MASK_IDX_W-1:0]   out_word_idx;
  logic                    out_last_word;
  logic                    out_last_row;

  modport master (
    output out_word, out_valid, out_row, out_word_idx, out_last_word, out_last_row,
    input  out_ready
  );

  modport slave (
    input  out_word, out_valid, out_row, out_word_idx, out_last_word, out_last_row,
    output out_ready
  );

endinterface

// File: rtl/mask_word_select.sv
// Slice mux: picks word word_idx out of the shadow row register.
//   shadow   : [0:shadow_w-1] captured row, bit 0 leftmost
//   word_idx : word index
//   word     : [0:word_w-1], lane k = shadow[word_idx*word_w+k], zero past the row end
module mask_word_select #(
  parameter int shadow_w = 1920,
  parameter int word_w   = 32,
  parameter int idx_w    = 6
) (
  input  logic [0:shadow_w-1] shadow,
  input  logic [idx_w-1:0]    word_idx,
  output logic [0:word_w-1]   word
);

  localparam int N_WORDS = (shadow_w + word_w - 1) / word_w;

  logic [0:word_w-1] words [N_WORDS];

  // Lanes beyond the register width (partial final word) read as zero.
  for (genvar w = 0; w < N_WORDS; w++) begin : g_word
    for (genvar k = 0; k < word_w; k++) begin : g_lane
      if (w * word_w + k < shadow_w) begin : g_pix
        assign words[w][k] = shadow[w * word_w + k];
      end else begin : g_pad
        assign words[w][k] = 1'b0;
      end
    end
  end

  always_comb begin
    word = '0;
    if (int'(word_idx) < N_WORDS) word = words[word_idx];
  end

endmodule

// File: rtl/mask_row_streamer.sv
// Captures one row mask per handshake from mask generation, slices it into
// word_w-pixel words and streams them to the mask loader tagged with row and
// word indices; pulses frame_done after the last row of the frame.
//   clk, rst_n        : clock, asynchronous active-low reset
//   clk_en            : global enable, everything holds when low
//   image_sensor_w/_h : frame size, latched on start (clamped to maxima)
//   start, abort      : frame request (IDLE only), synchronous abort
//   mg_mask/valid/ready : row mask input handshake
//   out_if            : word stream (see mask_row_streamer_if)
//   busy, frame_done  : not-IDLE flag, end-of-frame pulse
module mask_row_streamer
  import mask_pkg::*;
#(
  parameter int max_image_sensor_w = 1920,
  parameter int max_image_sensor_h = 1080,
  parameter int word_w             = MASK_WORD_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic [MASK_DIM_W-1:0]         image_sensor_w,
  input  logic [MASK_DIM_W-1:0]         image_sensor_h,
  input  logic                          start,
  input  logic                          abort,
  input  logic [0:max_image_sensor_w-1] mg_mask,
  input  logic                          mg_valid,
  output logic                          mg_ready,
  mask_row_streamer_if.master           out_if,
  output logic                          busy,
  output logic                          frame_done
);

  localparam logic [11:0] MAX_W12 = 12'(max_image_sensor_w);
  localparam logic [11:0] MAX_H12 = 12'(max_image_sensor_h);

  ms_state_t                     state, state_d;
  logic [MASK_DIM_W-1:0]         w_l, h_l;
  logic [11:0]                   nw;
  logic [MASK_DIM_W-1:0]         row, row_d;
  logic [MASK_IDX_W-1:0]         word_idx, word_idx_d;
  logic [0:max_image_sensor_w-1] shadow;
  logic [0:max_image_sensor_w-1] keep;
  logic                          out_valid_q;

  logic [MASK_DIM_W-1:0]         w_clamp, h_clamp;
  logic                          load, capture;
  logic                          last_word, last_row;

  assign w_clamp = ({1'b0, image_sensor_w} > MAX_W12) ? MAX_W12[MASK_DIM_W-1:0] : image_sensor_w;
  assign h_clamp = ({1'b0, image_sensor_h} > MAX_H12) ? MAX_H12[MASK_DIM_W-1:0] : image_sensor_h;

  // Pixels at or beyond the latched width are dropped at capture time.
  for (genvar i = 0; i < max_image_sensor_w; i++) begin : g_keep
    assign keep[i] = ({1'b0, w_l} > 12'(i));
  end

  assign last_word = (12'(word_idx) == nw - 12'd1);
  assign last_row  = (row == h_l - 11'd1);

  always_comb begin
    state_d    = state;
    row_d      = row;
    word_idx_d = word_idx;
    load       = 1'b0;
    capture    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            load  = 1'b1;
            row_d = '0;
            state_d = (w_clamp == '0 || h_clamp == '0) ? DONE : WAIT_MASK;
          end
        end
        WAIT_MASK: begin
          if (mg_valid) begin
            capture    = 1'b1;
            word_idx_d = '0;
            state_d    = SEND;
          end
        end
        SEND: begin
          if (out_if.out_ready) begin
            if (!last_word) begin
              word_idx_d = word_idx + 1'b1;
            end else if (!last_row) begin
              row_d   = row + 11'd1;
              state_d = WAIT_MASK;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake outputs are registered from the next state so they line up
  // with the state they describe without any input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      w_l         <= '0;
      h_l         <= '0;
      nw          <= '0;
      row         <= '0;
      word_idx    <= '0;
      shadow      <= '0;
      mg_ready    <= 1'b0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else if (clk_en) begin
      state    <= state_d;
      row      <= row_d;
      word_idx <= word_idx_d;
      if (load) begin
        w_l <= w_clamp;
        h_l <= h_clamp;
        nw  <= mask_word_count({1'b0, w_clamp}, 12'(word_w));
      end
      if (capture) shadow <= mg_mask & keep;
      mg_ready    <= (state_d == WAIT_MASK);
      out_valid_q <= (state_d == SEND);
      busy        <= (state_d != IDLE);
      frame_done  <= (state_d == DONE);
    end
  end

  mask_word_select #(
    .shadow_w (max_image_sensor_w),
    .word_w   (word_w),
    .idx_w    (MASK_IDX_W)
  ) u_word_select (
    .shadow   (shadow),
    .word_idx (word_idx),
    .word     (out_if.out_word)
  );

  assign out_if.out_valid     = out_valid_q;
  assign out_if.out_row       = row;
  assign out_if.out_word_idx  = word_idx;
  assign out_if.out_last_word = out_valid_q && last_word;
  assign out_if.out_last_row  = out_valid_q && last_row;

endmodule

// File: tb/tb_mask_row_streamer.sv
module tb_mask_row_streamer;

  localparam int MAXW = 1920;
  localparam int MAXH = 1080;
  localparam int WW   = 32;

  logic            clk = 1'b0;
  logic            rst_n, clk_en, start, abort, mg_valid, mg_ready, busy, frame_done;
  logic [10:0]     image_sensor_w, image_sensor_h;
  logic [0:MAXW-1] mg_mask;

  int vectors     = 0;
  int miscompares = 0;

  bit          row_mask [MAXW];
  logic [0:63] pat;

  mask_row_streamer_if #(.word_w(WW)) oif ();

  mask_row_streamer #(
    .max_image_sensor_w (MAXW),
    .max_image_sensor_h (MAXH),
    .word_w             (WW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clk_en         (clk_en),
    .image_sensor_w (image_sensor_w),
    .image_sensor_h (image_sensor_h),
    .start          (start),
    .abort          (abort),
    .mg_mask        (mg_mask),
    .mg_valid       (mg_valid),
    .mg_ready       (mg_ready),
    .out_if         (oif),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word j of the current row: pixels j*WW+k, zero at or beyond the width.
  function automatic logic [0:WW-1] exp_word(input int wl, input int j);
    logic [0:WW-1] e;
    for (int k = 0; k < WW; k++) begin
      int pix;
      pix  = j * WW + k;
      e[k] = (pix < wl) ? row_mask[pix] : 1'b0;
    end
    return e;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".out_valid"}, oif.out_valid, 0);
    chk({tag, ".mg_ready"}, mg_ready, 0);
    chk({tag, ".frame_done"}, frame_done, 0);
  endtask

  task automatic check_word(input int r, input int j, input int wl, input int hl, input int nw);
    chk("out_valid", oif.out_valid, 1);
    chk("out_word", oif.out_word, exp_word(wl, j));
    chk("out_row", oif.out_row, r);
    chk("out_word_idx", oif.out_word_idx, j);
    chk("out_last_word", oif.out_last_word, (j == nw - 1));
    chk("out_last_row", oif.out_last_row, (r == hl - 1));
    chk("frame_done_mid", frame_done, 0);
    chk("mg_ready_send", mg_ready, 0);
  endtask

  // mask_mode: 0 random, 1 all ones, 2 fixed pattern held valid.
  // ready_mode: 0 always ready, 1 one stall per word, 2 random stalls.
  // intr_row: row at which to abort (intr_kind 0) or reset (1); -1 none.
  // stall_row: row in which clk_en is held low for 5 cycles mid-row; -1 none.
  task automatic stream_frame(input int w, input int h, input int ready_mode,
                              input int mask_mode, input int intr_row,
                              input int intr_kind, input int stall_row);
    int wl, hl, nw;
    wl = (w > MAXW) ? MAXW : w;
    hl = (h > MAXH) ? MAXH : h;
    nw = (wl + WW - 1) / WW;

    image_sensor_w = 11'(w);
    image_sensor_h = 11'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    image_sensor_w = 11'($urandom);
    image_sensor_h = 11'($urandom);

    if (wl == 0 || hl == 0) begin
      chk("zero.frame_done", frame_done, 1);
      chk("zero.out_valid", oif.out_valid, 0);
      chk("zero.mg_ready", mg_ready, 0);
      tick();
      check_idle("zero.after");
      return;
    end

    for (int r = 0; r < hl; r++) begin
      chk("mg_ready_wait", mg_ready, 1);
      chk("out_valid_wait", oif.out_valid, 0);
      for (int i = 0; i < MAXW; i++) begin
        if (mask_mode == 1)      row_mask[i] = 1'b1;
        else if (mask_mode == 2) row_mask[i] = (i < 64) ? pat[i] : 1'($urandom_range(0, 1));
        else                     row_mask[i] = 1'($urandom_range(0, 1));
        mg_mask[i] = row_mask[i];
      end
      if (mask_mode != 2) begin
        repeat ($urandom_range(0, 2)) begin
          mg_valid = 1'b0;
          tick();
          chk("mg_ready_hold", mg_ready, 1);
        end
      end
      mg_valid = 1'b1;
      tick();
      if (mask_mode != 2) begin
        mg_valid = 1'b0;
        for (int i = 0; i < MAXW; i++) mg_mask[i] = 1'($urandom_range(0, 1));
      end

      for (int j = 0; j < nw; j++) begin
        int stalls;
        if (r == intr_row && j == 0) begin
          check_word(r, j, wl, hl, nw);
          oif.out_ready = 1'b1;
          if (intr_kind == 0) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_idle("abort");
          end else begin
            rst_n = 1'b0;
            #1;
            check_idle("reset_async");
            tick();
            rst_n = 1'b1;
            check_idle("reset");
            chk("reset.out_row", oif.out_row, 0);
            chk("reset.out_word_idx", oif.out_word_idx, 0);
          end
          mg_valid = 1'b0;
          repeat (2) begin
            tick();
            check_idle("post_intr");
          end
          return;
        end
        stalls = (ready_mode == 1) ? 1 : (ready_mode == 2) ? $urandom_range(0, 2) : 0;
        repeat (stalls) begin
          oif.out_ready = 1'b0;
          start = 1'($urandom_range(0, 1));
          check_word(r, j, wl, hl, nw);
          tick();
        end
        start = 1'b0;
        if (r == stall_row && j == nw / 2) begin
          clk_en = 1'b0;
          oif.out_ready = 1'b1;
          repeat (5) begin
            check_word(r, j, wl, hl, nw);
            tick();
          end
          clk_en = 1'b1;
        end
        oif.out_ready = 1'b1;
        check_word(r, j, wl, hl, nw);
        tick();
        oif.out_ready = 1'($urandom_range(0, 1));
      end
    end
    mg_valid = 1'b0;
    chk("done.frame_done", frame_done, 1);
    chk("done.out_valid", oif.out_valid, 0);
    chk("done.busy", busy, 1);
    tick();
    check_idle("done.after");
  endtask

  initial begin
    rst_n          = 1'b1;
    clk_en         = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    mg_valid       = 1'b0;
    mg_mask        = '0;
    image_sensor_w = '0;
    image_sensor_h = '0;
    oif.out_ready  = 1'b0;
    pat            = 64'hA5A5A5A5_0F0F0F0F;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_idle("rst");
    chk("rst.out_word", oif.out_word, 0);
    chk("rst.out_row", oif.out_row, 0);
    chk("rst.out_word_idx", oif.out_word_idx, 0);
    chk("rst.out_last_word", oif.out_last_word, 0);
    chk("rst.out_last_row", oif.out_last_row, 0);
    rst_n = 1'b1;
    tick();
    check_idle("rst.release");

    stream_frame(64, 2, 0, 2, -1, 0, -1);     // fixed pattern, held valid
    stream_frame(40, 1, 0, 1, -1, 0, -1);     // partial last word
    stream_frame(96, 2, 1, 0, -1, 0, -1);     // alternating ready
    stream_frame(96, 2, 0, 0, -1, 0, 1);      // clk_en hold mid-row
    stream_frame(64, 6, 0, 0, 3, 0, -1);      // abort in row 3
    stream_frame(64, 2, 2, 0, -1, 0, -1);
    stream_frame(64, 4, 0, 0, 2, 1, -1);      // reset mid-frame
    stream_frame(32, 1, 0, 0, -1, 0, -1);
    stream_frame(0, 5, 0, 0, -1, 0, -1);      // zero width
    stream_frame(10, 0, 0, 0, -1, 0, -1);     // zero height
    stream_frame(2047, 2, 2, 0, -1, 0, -1);   // width clamp: 60 words
    stream_frame(20, 2047, 0, 0, -1, 0, -1);  // height clamp: 1080 rows
    for (int f = 0; f < 6; f++)
      stream_frame($urandom_range(1, 300), $urandom_range(1, 3),
                   $urandom_range(0, 2), 0, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mask_row_streamer.md
# mask_row_streamer

Consumer end of the mask generator's row interface. Captures one full-width row mask per handshake, slices it into fixed-width words and streams them with a valid/ready handshake to the pixel-array mask loader, tagged with row and word indices. After `image_sensor_h` rows it pulses `frame_done` and returns to idle. It sits between `mask_generation` and the sensor-side column drivers.

## Interface
Parameters:
- `max_image_sensor_w`, 1920: maximum row width in pixels; sets the capture register width.
- `max_image_sensor_h`, 1080: maximum number of rows per frame.
- `word_w`, 32: output word width in pixels.

Ports:
- `clk`  in  1  single clock; all state is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  global enable; when low, all state, counters and outputs hold.
- `image_sensor_w`  in  11  active row width; latched on `start`.
- `image_sensor_h`  in  11  active row count; latched on `start`.
- `start`  in  1  single-cycle request to stream one frame; ignored unless in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE on the next enabled edge.
- `mg_mask`  in  max_image_sensor_w  row mask, `[0:max-1]`, where bit 0 is the leftmost pixel.
- `mg_valid`  in  1  row mask is valid (level).
- `mg_ready`  out  1  high only in WAIT_MASK.
- `out_word`  out  word_w  `[0:word_w-1]`; lane k is pixel `word_idx*word_w+k`.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  downstream accepts.
- `out_row`  out  11  row index of `out_word`.
- `out_word_idx`  out  6  word index within the row.
- `out_last_word`  out  1  current word is the last word of its row.
- `out_last_row`  out  1  current row is the last row of the frame.
- `busy`  out  1  state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Latched width: `w_l = min(image_sensor_w, max_image_sensor_w)`. Latched height: `h_l = min(image_sensor_h, max_image_sensor_h)`.
- Words per row: `nw = ceil(w_l/word_w)`, computed with 12-bit arithmetic.
- IDLE: `start`=1 with `w_l`=0 or `h_l`=0 → DONE. Otherwise → WAIT_MASK with row=0.
- WAIT_MASK: `mg_ready`=1.
  - When `mg_valid`&&`mg_ready`, capture `mg_mask` into the shadow register. Bits with index ≥ `w_l` are forced to 0.
  - Set word_idx=0 and go to SEND.
- SEND: `out_valid`=1, and `out_word` = shadow slice at word_idx. Each `out_valid`&&`out_ready` advances as follows:
  - If word_idx < nw-1: word_idx++.
  - Else if row < h_l-1: row++ and go to WAIT_MASK.
  - Else go to DONE.
- DONE: `frame_done`=1 for one cycle, then → IDLE.
- A handshake counts only on an edge where `clk_en`=1.
- `abort` in any state → IDLE. The shadow register is not cleared. `frame_done` does not pulse.
- `abort` has priority over a simultaneous handshake.
- `start` outside IDLE is ignored.
- Reset values: state IDLE; all outputs 0; row, word_idx and shadow register 0.
- Reset mid-frame: the next `start` begins again at row 0.

## Timing
- All outputs are driven from registers or state decode only. There is no combinational path from any input to any output.
- `start` accepted at edge t → `mg_ready`=1 from t+1.
- Mask capture at edge c → `out_valid`=1 from c+1, with word 0.
- While `out_valid`=1 and `out_ready`=0, `out_word`, `out_row`, `out_word_idx`, `out_last_word` and `out_last_row` stay stable.
- `out_valid` never drops without a handshake, except on `abort`, reset, or a hold caused by `clk_en`=0.
- Minimum row period is nw+1 cycles: one capture cycle plus nw word cycles.
- Last handshake at edge e → `frame_done` high during cycle e+1 → `busy`=0 from e+2.
- Zero-size frame: `start` at t → `frame_done` during t+1. `out_valid` never asserts.

## Structure
- Shared package `mask_pkg` holds:
  - the `ms_state_t` enum: IDLE, WAIT_MASK, SEND, DONE;
  - the `MASK_WORD_W` default;
  - the `MASK_IDX_W` = $clog2(ceil(1920/32)) constant;
  - the word-count function.
- One sub-module, `mask_word_select`: a parameterised slice mux (shadow, word_idx → word). The FSM and counters stay in the top module.

## Test plan
- w=64, h=2, `mg_mask`[0:63]=0xA5A5A5A5_0F0F0F0F held valid, `out_ready`=1 → exactly 4 words: A5A5A5A5, 0F0F0F0F, A5A5A5A5, 0F0F0F0F. Rows are 0,0,1,1. `out_last_word` is high on words 2 and 4. `out_last_row` is high on the last two words. `frame_done` pulses once.
- w=40, h=1, `mg_mask` all ones → 2 words: 0xFFFFFFFF, then 0xFF000000 (lanes 8..31 zero).
- w=96, `out_ready` alternating 0/1 → 3 words per row with no duplicate or skip. Word held stable while `out_ready`=0.
- `clk_en` low for 5 cycles mid-SEND → state, indices and `out_word` unchanged. Streaming resumes with the same word.
- `abort` during row 3, or `rst_n` low mid-frame → `out_valid`=0 and `busy`=0 on the next cycle, no `frame_done`. A following `start` streams from row 0.
- `image_sensor_w`=0 with `start` → `frame_done` one cycle later, zero words. `image_sensor_w`=2047 → clamped to 1920, so 60 words per row.
